// File: rtl/multicycle_pkg.sv
// Shared encodings for the multicycle RV32I control unit and its datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_pkg;

  // Controller states; encodings 12..15 are unreachable and recover to FETCH.
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_ILLEGAL  = 4'd11
  } state_t;

  // ALU operation class handed from the FSM to the ALU decoder.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Result mux select.
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // ALU A operand select.
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // ALU B operand select.
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // ALU function codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Opcodes recognised by the controller.
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Immediate formats understood by the extender.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the instruction register/ALU flags and the datapath controls.
// Latency: n/a (wires only).
// Backpressure: none; every control is valid each cycle.
interface multicycle_ctrl_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pcwrite;
  logic       adrsrc;
  logic       memwrite;
  logic       irwrite;
  logic [1:0] resultsrc;
  logic [1:0] alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regwrite;
  logic [1:0] immsrc;
  logic       illegal;

  // Controller side: consumes instruction fields, drives the datapath.
  modport master (
    input  op, funct3, funct7b5, zero,
    output pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           alucontrol, regwrite, immsrc, illegal
  );

  // Datapath side: supplies instruction fields, obeys the controls.
  modport slave (
    output op, funct3, funct7b5, zero,
    input  pcwrite, adrsrc, memwrite, irwrite, resultsrc, alusrca, alusrcb,
           alucontrol, regwrite, immsrc, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the FSM's ALU operation class plus instruction fields to an ALU function.
// Latency: purely combinational.
// Backpressure: none.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       op5,
  output logic [2:0] alucontrol
);

  // Only R-type (op5=1) with funct7b5 set selects subtract; addi never does.
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM sequencing fetch/decode/execute/writeback for the RV32I core.
// Latency: lw 5, sw 4, ALU 4, branch 3, jal 4, illegal 3 cycles (or parked when halting).
// Backpressure: none; the datapath is assumed to complete every step in one cycle.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  multicycle_ctrl_if.master  bus
);

  state_t     state;
  state_t     next_state;
  state_t     out_state;
  logic       pcupdate;
  logic       branch;
  logic       take;
  logic [1:0] aluop;

  // State register; reset always lands in FETCH so an aborted instruction restarts cleanly.
  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= next_state;
  end

  // Next-state decode; unreachable encodings fall back to FETCH.
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_R:              next_state = S_EXECR;
          OP_I:              next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BRANCH;
          OP_JAL:            next_state = S_JAL;
          default:           next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR:   next_state = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  next_state = S_MEMWB;
      S_MEMWB:    next_state = S_FETCH;
      S_MEMWRITE: next_state = S_FETCH;
      S_EXECR:    next_state = S_ALUWB;
      S_EXECI:    next_state = S_ALUWB;
      S_ALUWB:    next_state = S_FETCH;
      S_BRANCH:   next_state = S_FETCH;
      S_JAL:      next_state = S_ALUWB;
      S_ILLEGAL:  next_state = ILLEGAL_HALT ? S_ILLEGAL : S_FETCH;
      default:    next_state = S_FETCH;
    endcase
  end

  // Moore outputs; while reset is high the datapath sees FETCH with every write enable dropped.
  always_comb begin
    out_state     = reset ? S_FETCH : state;
    pcupdate      = 1'b0;
    branch        = 1'b0;
    aluop         = ALUOP_ADD;
    bus.adrsrc    = 1'b0;
    bus.memwrite  = 1'b0;
    bus.irwrite   = 1'b0;
    bus.resultsrc = RES_ALUOUT;
    bus.alusrca   = SRCA_PC;
    bus.alusrcb   = SRCB_RS2;
    bus.regwrite  = 1'b0;
    bus.illegal   = 1'b0;
    case (out_state)
      S_FETCH: begin
        bus.irwrite   = 1'b1;
        bus.alusrcb   = SRCB_FOUR;
        bus.resultsrc = RES_ALURESULT;
        pcupdate      = 1'b1;
      end
      S_DECODE: begin
        bus.alusrca = SRCA_OLDPC;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEMADR: begin
        bus.alusrca = SRCA_RS1;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEMREAD: begin
        bus.adrsrc = 1'b1;
      end
      S_MEMWB: begin
        bus.resultsrc = RES_DATA;
        bus.regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        bus.adrsrc   = 1'b1;
        bus.memwrite = 1'b1;
      end
      S_EXECR: begin
        bus.alusrca = SRCA_RS1;
        aluop       = ALUOP_FUNCT;
      end
      S_EXECI: begin
        bus.alusrca = SRCA_RS1;
        bus.alusrcb = SRCB_IMM;
        aluop       = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        bus.regwrite = 1'b1;
      end
      S_BRANCH: begin
        bus.alusrca = SRCA_RS1;
        aluop       = ALUOP_SUB;
        branch      = 1'b1;
      end
      S_JAL: begin
        bus.alusrca = SRCA_OLDPC;
        bus.alusrcb = SRCB_FOUR;
        pcupdate    = 1'b1;
      end
      S_ILLEGAL: begin
        bus.illegal = 1'b1;
      end
      default: begin
        bus.resultsrc = RES_ALUOUT;
      end
    endcase
    if (reset) begin
      bus.memwrite = 1'b0;
      bus.irwrite  = 1'b0;
      bus.regwrite = 1'b0;
    end
  end

  // Branch condition: beq on zero, bne on not-zero, other funct3 never taken.
  always_comb begin
    take = 1'b0;
    case (bus.funct3)
      3'b000:  take = bus.zero;
      3'b001:  take = ~bus.zero;
      default: take = 1'b0;
    endcase
  end

  assign bus.pcwrite = ~reset & (pcupdate | (branch & take));

  // Immediate format follows the opcode directly so the extender is ready in DECODE.
  always_comb begin
    bus.immsrc = IMM_I;
    case (bus.op)
      OP_STORE:  bus.immsrc = IMM_S;
      OP_BRANCH: bus.immsrc = IMM_B;
      OP_JAL:    bus.immsrc = IMM_J;
      default:   bus.immsrc = IMM_I;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (bus.funct3),
    .funct7b5   (bus.funct7b5),
    .op5        (bus.op[5]),
    .alucontrol (bus.alucontrol)
  );

endmodule
